// File: rtl/soc_wb_pkg.sv
// Shared Wishbone definitions: cycle-type/burst encodings and arbiter state type.
package soc_wb_pkg;

    // Cycle type identifier encodings
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Burst type extension encodings
    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    // Arbiter ownership state
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/soc_arb_rr.sv
// Round-robin next-grant search: first requester after 'last', wrapping.
module soc_arb_rr
    import soc_wb_pkg::*;
#(
    parameter int unsigned MASTERS = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic [MASTERS-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [MASTERS-1:0] nxt
);

    // Scan offsets 1..MASTERS from last; the first asserted request wins
    always_comb begin
        logic        found;
        int unsigned idx;
        nxt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= MASTERS; k++) begin
            idx = (int'(last) + k) % MASTERS;
            if (!found && req[IDX_W'(idx)]) begin
                nxt[IDX_W'(idx)] = 1'b1;
                found            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/soc_arbiter_wb.sv
// Wishbone N-master to 1-slave arbiter with round-robin, whole-cycle ownership.
module soc_arbiter_wb
    import soc_wb_pkg::*;
#(
    parameter int unsigned MASTERS    = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,

    input  logic [MASTERS-1:0][ADDR_WIDTH-1:0]   m_adr_i,
    input  logic [MASTERS-1:0][DATA_WIDTH-1:0]   m_dat_i,
    input  logic [MASTERS-1:0][DATA_WIDTH/8-1:0] m_sel_i,
    input  logic [MASTERS-1:0][2:0]              m_cti_i,
    input  logic [MASTERS-1:0][1:0]              m_bte_i,
    input  logic [MASTERS-1:0]                   m_cyc_i,
    input  logic [MASTERS-1:0]                   m_stb_i,
    input  logic [MASTERS-1:0]                   m_we_i,

    output logic [MASTERS-1:0][DATA_WIDTH-1:0]   m_dat_o,
    output logic [MASTERS-1:0]                   m_ack_o,
    output logic [MASTERS-1:0]                   m_err_o,
    output logic [MASTERS-1:0]                   m_rty_o,

    output logic [ADDR_WIDTH-1:0]                s_adr_o,
    output logic [DATA_WIDTH-1:0]                s_dat_o,
    output logic [DATA_WIDTH/8-1:0]              s_sel_o,
    output logic                                 s_we_o,
    output logic                                 s_cyc_o,
    output logic                                 s_stb_o,
    output logic [2:0]                           s_cti_o,
    output logic [1:0]                           s_bte_o,

    input  logic [DATA_WIDTH-1:0]                s_dat_i,
    input  logic                                 s_ack_i,
    input  logic                                 s_err_i,
    input  logic                                 s_rty_i
);

    localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned IDX_W     = (MASTERS > 1) ? $clog2(MASTERS) : 1;

    arb_state_e          state, state_nxt;
    logic [MASTERS-1:0]  grant, grant_nxt;
    logic [IDX_W-1:0]    last, last_nxt;
    logic [MASTERS-1:0]  rr_nxt;
    logic [IDX_W-1:0]    rr_idx;
    logic [IDX_W-1:0]    sel_idx;
    logic                busy;

    soc_arb_rr #(
        .MASTERS (MASTERS),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req  (m_cyc_i),
        .last (last),
        .nxt  (rr_nxt)
    );

    // One-hot round-robin winner to index
    always_comb begin
        rr_idx = '0;
        for (int i = 0; i < MASTERS; i++) begin
            if (rr_nxt[i]) rr_idx = IDX_W'(i);
        end
    end

    // State, grant and last-owner registers; reset leaves master 0 first in line
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ARB_IDLE;
            grant <= '0;
            last  <= IDX_W'(MASTERS - 1);
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            last  <= last_nxt;
        end
    end

    // Next-state: grant from IDLE, release to IDLE when the owner drops cyc
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last;
        case (state)
            ARB_IDLE: begin
                if (|m_cyc_i) begin
                    state_nxt = ARB_BUSY;
                    grant_nxt = rr_nxt;
                    last_nxt  = rr_idx;
                end
            end
            ARB_BUSY: begin
                if (!m_cyc_i[last]) begin
                    state_nxt = ARB_IDLE;
                    grant_nxt = '0;
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    // The owner's index is 'last' while busy; master 0 otherwise so outputs stay defined
    always_comb begin
        busy    = (state == ARB_BUSY);
        sel_idx = busy ? last : '0;
    end

    // Slave-side mux from the selected master; cyc/stb suppressed when idle
    always_comb begin
        s_adr_o = m_adr_i[sel_idx];
        s_dat_o = m_dat_i[sel_idx];
        s_sel_o = SEL_WIDTH'(m_sel_i[sel_idx]);
        s_we_o  = m_we_i[sel_idx];
        s_cti_o = m_cti_i[sel_idx];
        s_bte_o = m_bte_i[sel_idx];
        s_cyc_o = busy & m_cyc_i[sel_idx];
        s_stb_o = busy & m_stb_i[sel_idx];
    end

    // Terminations steered to the owner only, qualified by its cyc; read data broadcast
    always_comb begin
        m_ack_o = grant & m_cyc_i & {MASTERS{s_ack_i}};
        m_err_o = grant & m_cyc_i & {MASTERS{s_err_i}};
        m_rty_o = grant & m_cyc_i & {MASTERS{s_rty_i}};
        for (int i = 0; i < MASTERS; i++) begin
            m_dat_o[i] = s_dat_i;
        end
    end

endmodule

// File: tb/tb_soc_arbiter_wb.sv
// Directed bench for soc_arbiter_wb with two 32-bit masters.
module tb_soc_arbiter_wb;
    import soc_wb_pkg::*;

    localparam int unsigned M  = 2;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam logic [31:0] A0 = 32'h0000_1000;
    localparam logic [31:0] A1 = 32'h0000_2000;

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic [M-1:0][AW-1:0]    m_adr_i;
    logic [M-1:0][DW-1:0]    m_dat_i;
    logic [M-1:0][DW/8-1:0]  m_sel_i;
    logic [M-1:0][2:0]       m_cti_i;
    logic [M-1:0][1:0]       m_bte_i;
    logic [M-1:0]            m_cyc_i, m_stb_i, m_we_i;
    logic [M-1:0][DW-1:0]    m_dat_o;
    logic [M-1:0]            m_ack_o, m_err_o, m_rty_o;
    logic [AW-1:0]           s_adr_o;
    logic [DW-1:0]           s_dat_o;
    logic [DW/8-1:0]         s_sel_o;
    logic                    s_we_o, s_cyc_o, s_stb_o;
    logic [2:0]              s_cti_o;
    logic [1:0]              s_bte_o;
    logic [DW-1:0]           s_dat_i;
    logic                    s_ack_i, s_err_i, s_rty_i;

    int total = 0;
    int bad   = 0;

    soc_arbiter_wb #(.MASTERS(M), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i   = 1'b1;
        m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_cti_i = '0; m_bte_i = '0;
        m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
        s_dat_i = '0; s_ack_i = 1'b1; s_err_i = 1'b0; s_rty_i = 1'b0;
        tick(); tick();

        // Reset state: no bus cycle, no terminations even with slave ack high
        chk("rst_cyc", 64'(s_cyc_o), 64'd0);
        chk("rst_stb", 64'(s_stb_o), 64'd0);
        chk("rst_ack", 64'(m_ack_o), 64'd0);
        s_ack_i = 1'b0;
        rst_i   = 1'b0;
        tick();

        // Single master 0 write
        m_adr_i[0] = A0; m_dat_i[0] = 32'hDEAD_BEEF; m_sel_i[0] = 4'hF;
        m_we_i[0] = 1'b1; m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1;
        #1;
        chk("w_cyc_before_edge", 64'(s_cyc_o), 64'd0);
        tick();
        chk("w_cyc_granted", 64'(s_cyc_o), 64'd1);
        chk("w_adr", 64'(s_adr_o), 64'(A0));
        chk("w_dat", 64'(s_dat_o), 64'hDEAD_BEEF);
        chk("w_we", 64'(s_we_o), 64'd1);
        chk("w_sel", 64'(s_sel_o), 64'hF);
        s_ack_i = 1'b1; #1;
        chk("w_ack", 64'(m_ack_o), 64'b01);
        s_dat_i = 32'h1234_5678; #1;
        chk("dat_broadcast", 64'(m_dat_o), {32'h1234_5678, 32'h1234_5678});
        tick();
        s_ack_i = 1'b0; m_cyc_i[0] = 1'b0; m_stb_i[0] = 1'b0; m_we_i[0] = 1'b0; #1;
        chk("w_cyc_drop", 64'(s_cyc_o), 64'd0);
        tick();

        // Simultaneous requests straight after reset: master 0 first
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        m_adr_i[1] = A1;
        m_cyc_i = 2'b11; m_stb_i = 2'b11;
        tick();
        chk("sim_first_adr", 64'(s_adr_o), 64'(A0));
        s_ack_i = 1'b1; #1;
        chk("sim_first_ack", 64'(m_ack_o), 64'b01);
        s_ack_i = 1'b0; m_cyc_i[0] = 1'b0; m_stb_i[0] = 1'b0;
        tick();
        chk("sim_idle_gap", 64'(s_cyc_o), 64'd0);
        tick();
        chk("sim_second_cyc", 64'(s_cyc_o), 64'd1);
        chk("sim_second_adr", 64'(s_adr_o), 64'(A1));
        s_ack_i = 1'b1; #1;
        chk("sim_second_ack", 64'(m_ack_o), 64'b10);
        s_ack_i = 1'b0; m_cyc_i[1] = 1'b0; m_stb_i[1] = 1'b0;
        tick();

        // Master 1 burst while master 0 waits; last was 1, so master 1 requests alone first
        m_cyc_i[1] = 1'b1; m_stb_i[1] = 1'b1; m_cti_i[1] = CTI_INCR;
        tick();
        chk("burst_owner", 64'(s_adr_o), 64'(A1));
        m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1;
        s_ack_i = 1'b1;
        m_cti_i[1] = CTI_INCR; #1;
        chk("burst_b0_cti", 64'(s_cti_o), 64'(CTI_INCR));
        chk("burst_b0_ack", 64'(m_ack_o), 64'b10);
        tick();
        chk("burst_b1_ack", 64'(m_ack_o), 64'b10);
        tick();
        chk("burst_b2_ack", 64'(m_ack_o), 64'b10);
        tick();
        m_cti_i[1] = CTI_EOB; #1;
        chk("burst_b3_cti", 64'(s_cti_o), 64'(CTI_EOB));
        chk("burst_b3_ack", 64'(m_ack_o), 64'b10);
        tick();
        s_ack_i = 1'b0; m_cyc_i[1] = 1'b0; m_stb_i[1] = 1'b0; m_cti_i[1] = CTI_CLASSIC;
        tick();
        chk("burst_release_idle", 64'(s_cyc_o), 64'd0);
        tick();
        chk("burst_m0_cyc", 64'(s_cyc_o), 64'd1);
        chk("burst_m0_adr", 64'(s_adr_o), 64'(A0));

        // Error termination during master 0's cycle
        s_err_i = 1'b1; #1;
        chk("err_err", 64'(m_err_o), 64'b01);
        chk("err_ack", 64'(m_ack_o), 64'b00);
        s_err_i = 1'b0; s_rty_i = 1'b1; #1;
        chk("rty_rty", 64'(m_rty_o), 64'b01);
        s_rty_i = 1'b0;
        tick();

        // Asynchronous reset mid-burst; both masters keep requesting
        m_cyc_i[1] = 1'b1; m_stb_i[1] = 1'b1; m_cti_i[0] = CTI_INCR;
        s_ack_i = 1'b1;
        #2;
        rst_i = 1'b1; #1;
        chk("arst_cyc", 64'(s_cyc_o), 64'd0);
        chk("arst_stb", 64'(s_stb_o), 64'd0);
        chk("arst_ack", 64'(m_ack_o), 64'b00);
        s_ack_i = 1'b0;
        tick(); tick();
        rst_i = 1'b0; #1;
        chk("arst_post_idle", 64'(s_cyc_o), 64'd0);
        tick();
        chk("arst_m0_first", 64'(s_adr_o), 64'(A0));
        m_cti_i[0] = CTI_CLASSIC;

        // Continuous requests: owners alternate 0,1,0,1
        for (int t = 0; t < 4; t++) begin
            chk($sformatf("alt_owner_%0d", t), 64'(s_adr_o), (t % 2 == 0) ? 64'(A0) : 64'(A1));
            chk($sformatf("alt_cyc_%0d", t), 64'(s_cyc_o), 64'd1);
            m_cyc_i[t % 2] = 1'b0;
            tick();
            m_cyc_i[t % 2] = 1'b1;
            tick();
        end

        m_cyc_i = '0; m_stb_i = '0;
        tick(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/soc_arbiter_wb.md
SOC_ARBITER_WB -- requirements
Module: soc_arbiter_wb

Interface
REQ-001 The block SHALL have parameter MASTERS, default 2: number of Wishbone masters, range 1..16.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32: data width in bits, a multiple of 8.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 32: address width in bits.
REQ-004 The block SHALL have local parameter SEL_WIDTH = DATA_WIDTH/8.
REQ-005 The block SHALL have port clk_i  input  1: the single clock; all state is on its rising edge.
REQ-006 The block SHALL have port rst_i  input  1: reset, asynchronous and active-high.
REQ-007 The block SHALL have master-side inputs, each a packed array [MASTERS-1:0] of the shown width:
- m_adr_i (ADDR_WIDTH), m_dat_i (DATA_WIDTH), m_sel_i (SEL_WIDTH), m_cti_i (3), m_bte_i (2)
- m_cyc_i, m_stb_i, m_we_i (1 each)
REQ-008 The block SHALL have master-side outputs:
- m_dat_o  [MASTERS-1:0][DATA_WIDTH-1:0]: read data, broadcast to all masters
- m_ack_o, m_err_o, m_rty_o  [MASTERS-1:0]: per-master termination
REQ-009 The block SHALL have slave-side outputs: s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o; widths as the matching m_*_i element.
REQ-010 The block SHALL have slave-side inputs: s_dat_i (DATA_WIDTH), s_ack_i, s_err_i, s_rty_i (1 each).

Function
REQ-011 The arbiter SHALL have two states:
- IDLE: no owner; s_cyc_o=0 and s_stb_o=0.
- BUSY: exactly one master owns the bus; grant is a one-hot register.
REQ-012 In IDLE, if any m_cyc_i bit is high at a rising edge, the arbiter SHALL enter BUSY and grant the first requester found searching from index (last+1) mod MASTERS upward with wrap; it SHALL then set last to the granted index.
REQ-013 Grant latency SHALL be one cycle: a request at edge N drives s_cyc_o from edge N+1.
REQ-014 In BUSY, all s_* outputs SHALL carry the granted master's signals, and s_cyc_o and s_stb_o SHALL be the granted master's m_cyc_i and m_stb_i, passed combinationally.
REQ-015 In BUSY, m_ack_o, m_err_o and m_rty_o of the granted master SHALL equal s_ack_i, s_err_i and s_rty_i ANDed with that master's m_cyc_i; these outputs SHALL be 0 for every other master.
REQ-016 Ownership SHALL be held for the whole cycle, including CTI bursts; other requests SHALL not preempt it.
REQ-017 In BUSY, when the granted master's m_cyc_i is low at a rising edge, the arbiter SHALL return to IDLE. It SHALL not re-grant at that same edge, so there is one idle cycle between owners.
REQ-018 m_dat_o[i] SHALL equal s_dat_i for every i, combinationally.
REQ-019 If grant changes, last SHALL update; if requests arrive simultaneously, the round-robin order SHALL decide, with no starvation: each requester waits at most MASTERS-1 tenures.
REQ-020 With MASTERS=1, the arbiter SHALL behave identically (grant always index 0, still registered).

Reset
REQ-021 Asserting rst_i SHALL force the following, at any time including mid-transfer:
- state=IDLE, grant=0, last=MASTERS-1, so master 0 wins first
- s_cyc_o=0, s_stb_o=0, all m_ack_o/m_err_o/m_rty_o=0
REQ-022 While in reset, data, address, sel, cti and bte outputs SHALL be don't-care-safe and SHALL be driven from master index 0.

Structure
REQ-023 The shared package soc_wb_pkg SHALL hold the CTI encodings (CLASSIC=3'b000, INCR=3'b010, EOB=3'b111) and the BTE encodings.
REQ-024 The round-robin next-grant logic SHALL be a combinational sub-module soc_arb_rr (inputs: req, last; output: one-hot nxt).

Verification
REQ-025 The bench SHALL cover these directed scenarios with MASTERS=2, DATA_WIDTH=32, ADDR_WIDTH=32:
- Single master 0 write, adr 0x0000_1000, dat 0xDEAD_BEEF -> s_cyc_o high one cycle after m_cyc_i[0]; m_ack_o=2'b01 on s_ack_i.
- Both masters assert m_cyc_i at the same edge after reset -> master 0 granted; after its cyc drops, one idle cycle, then master 1 granted.
- Master 1 runs a 4-beat INCR burst (cti 010,010,010,111) while master 0 requests -> four acks to master 1 only; master 0 is granted after release.
- s_err_i pulsed during master 0's cycle -> m_err_o=2'b01 and m_ack_o=2'b00 that cycle.
- rst_i asserted mid-burst -> s_cyc_o=0 immediately (asynchronously); after release, master 0 regains priority.
- Master 1 requesting continuously and master 0 requesting continuously -> grants alternate 0,1,0,1 over 4 tenures.
